// File: rtl/hello_ram_tester.sv
// hello_ram_tester: Avalon-MM master that fills or verifies a word range of the HELLO RAM
module hello_ram_tester #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 5000,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [ADDR_W+1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
);
    typedef enum logic [2:0] {IDLE, WRITE, RREQ, RWAIT, DONE} state_t;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] base_wrap;
    logic [ADDR_W:0]   rem;
    logic [DATA_W-1:0] data;
    logic              last;
    assign avm_byteenable = 4'hF;
    // base folded into the RAM range, next wrapped address, and last-word detect
    always_comb begin
        base_wrap = (base >= ADDR_W'(DEPTH)) ? base - ADDR_W'(DEPTH) : base;
        addr_nxt  = (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
        last      = rem == (ADDR_W + 1)'(1);
    end
    // command FSM with registered bus outputs; rem counts words still to finish
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            addr           <= '0;
            data           <= '0;
            rem            <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr           <= base_wrap;
                    data           <= seed;
                    rem            <= count;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    avm_address    <= {base_wrap, 2'b00};
                    avm_writedata  <= seed;
                    if (count == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        busy      <= 1'b1;
                        avm_read  <= mode;
                        avm_write <= ~mode;
                        state     <= mode ? RREQ : WRITE;
                    end
                end
                WRITE: if (!avm_waitrequest) begin
                    if (last) begin
                        avm_write <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rem           <= rem - (ADDR_W + 1)'(1);
                        addr          <= addr_nxt;
                        data          <= data + DATA_W'(1);
                        avm_address   <= {addr_nxt, 2'b00};
                        avm_writedata <= data + DATA_W'(1);
                    end
                end
                RREQ: if (!avm_waitrequest) begin
                    avm_read <= 1'b0;
                    state    <= RWAIT;
                end
                RWAIT: if (avm_readdatavalid) begin
                    if (avm_readdata != data) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == '0) first_err_addr <= addr;
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rem         <= rem - (ADDR_W + 1)'(1);
                        addr        <= addr_nxt;
                        data        <= data + DATA_W'(1);
                        avm_address <= {addr_nxt, 2'b00};
                        avm_read    <= 1'b1;
                        state       <= RREQ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hello_ram_tester.sv
// tb_hello_ram_tester: directed and randomized fill/verify runs against a word-level RAM model
module tb_hello_ram_tester;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 5000;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              mode = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W:0]   count = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              busy;
    logic              done;
    logic [15:0]       err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W+1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata = '0;
    logic              avm_readdatavalid = 1'b0;
    logic              avm_waitrequest = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] ram   [DEPTH];
    logic [31:0] model [DEPTH];

    int          stall_pct = 0;
    int          force_stall = 0;
    int          stalls = 0;
    int          wr_idx = 0;
    int          rd_cnt = 0;
    int          op_base = 0;
    logic [31:0] op_seed = '0;
    bit          hold_valid = 1'b0;

    logic              pr_rd = 1'b0;
    logic              pr_wr = 1'b0;
    logic              pr_wait = 1'b0;
    logic [ADDR_W+1:0] pr_addr = '0;
    logic [31:0]       pr_data = '0;

    always #5 clk = ~clk;

    hello_ram_tester #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .mode(mode),
        .base(base),
        .count(count),
        .seed(seed),
        .busy(busy),
        .done(done),
        .err_count(err_count),
        .first_err_addr(first_err_addr),
        .avm_address(avm_address),
        .avm_byteenable(avm_byteenable),
        .avm_read(avm_read),
        .avm_write(avm_write),
        .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock of the RAM slave: commits last cycle's accepted transfer, returns
    // read data one cycle after acceptance, then chooses this cycle's waitrequest
    task automatic step();
        @(posedge clk);
        #1;
        avm_readdatavalid = 1'b0;
        if (pr_wr && !pr_wait) begin
            chk("wr_addr", 64'(pr_addr), 64'(((op_base + wr_idx) % DEPTH) * 4));
            chk("wr_data", 64'(pr_data), 64'(op_seed + 32'(wr_idx)));
            ram[int'(pr_addr >> 2) % DEPTH] = pr_data;
            wr_idx++;
        end
        if (pr_rd && !pr_wait) begin
            chk("rd_addr", 64'(pr_addr), 64'(((op_base + rd_cnt) % DEPTH) * 4));
            rd_cnt++;
            if (!hold_valid) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = ram[int'(pr_addr >> 2) % DEPTH];
            end
        end
        if (pr_wait && (pr_rd || pr_wr))
            chk("stall_hold", 64'({avm_read, avm_write, avm_address, pr_wr ? avm_writedata : 32'h0}),
                64'({pr_rd, pr_wr, pr_addr, pr_wr ? pr_data : 32'h0}));
        chk("rw_excl", 64'(avm_read & avm_write), 64'(0));
        avm_waitrequest = 1'b0;
        if (avm_read || avm_write) begin
            if (force_stall > 0) begin
                avm_waitrequest = 1'b1;
                force_stall--;
            end else avm_waitrequest = ($urandom_range(99) < stall_pct);
        end
        if (avm_waitrequest) stalls++;
        pr_rd = avm_read;
        pr_wr = avm_write;
        pr_wait = avm_waitrequest;
        pr_addr = avm_address;
        pr_data = avm_writedata;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_read"}, 64'(avm_read), 64'(0));
        chk({tag, "_write"}, 64'(avm_write), 64'(0));
        chk({tag, "_addr"}, 64'(avm_address), 64'(0));
        chk({tag, "_wdata"}, 64'(avm_writedata), 64'(0));
        chk({tag, "_err"}, 64'(err_count), 64'(0));
        chk({tag, "_first"}, 64'(first_err_addr), 64'(0));
        chk({tag, "_be"}, 64'(avm_byteenable), 64'(4'hF));
    endtask

    // pulse start for one edge, then scramble the command inputs to prove they were latched
    task automatic launch(input bit m, input int b, input int n, input logic [31:0] s);
        op_base = b;
        op_seed = s;
        wr_idx = 0;
        rd_cnt = 0;
        stalls = 0;
        mode = m;
        base = ADDR_W'(b);
        count = (ADDR_W + 1)'(n);
        seed = s;
        start = 1'b1;
        step();
        start = 1'b0;
        mode = 1'($urandom);
        base = ADDR_W'($urandom);
        count = (ADDR_W + 1)'($urandom);
        seed = $urandom;
    endtask

    // full operation: the model predicts the RAM image (fill) or the mismatch
    // tally (verify) and the cycle count from word counts plus injected stalls
    task automatic run_op(input bit m, input int b, input int n, input logic [31:0] s, input bit poke);
        int exp_err = 0;
        int exp_first = 0;
        int cyc = 1;
        int budget = 4 * n + 200;
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            int a = (b + i) % DEPTH;
            if (!m) model[a] = s + 32'(i);
            else if (model[a] !== s + 32'(i)) begin
                if (exp_err == 0) exp_first = a;
                if (exp_err < 65535) exp_err++;
            end
        end
        launch(m, b, n, s);
        while (!seen && cyc < budget) begin
            if (done) seen = 1'b1;
            else begin
                chk("busy_op", 64'(busy), 64'(1));
                start = poke && cyc == 2;
                step();
                start = 1'b0;
                cyc++;
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("latency", 64'(cyc), 64'((m ? 2 * n : n) + stalls + 1));
        chk("busy_done", 64'(busy), 64'(0));
        chk("err_count", 64'(err_count), 64'(exp_err));
        chk("first_err", 64'(first_err_addr), 64'(exp_first));
        chk("n_writes", 64'(wr_idx), 64'(m ? 0 : n));
        chk("n_reads", 64'(rd_cnt), 64'(m ? n : 0));
        step();
        chk("done_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        int b, n, a, lb;
        bit m;
        logic [31:0] s, ls, v;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            model[i] = '0;
        end
        step();
        step();
        chk_reset("init");
        reset_n = 1'b1;
        step();

        run_op(1'b0, 0, 4, 32'hA5A50000, 1'b0);
        run_op(1'b1, 0, 4, 32'hA5A50000, 1'b0);

        ram[2] = 32'hDEADBEEF;
        model[2] = 32'hDEADBEEF;
        run_op(1'b1, 0, 4, 32'hA5A50000, 1'b0);
        chk("corrupt_err", 64'(err_count), 64'(1));
        chk("corrupt_first", 64'(first_err_addr), 64'(2));

        force_stall = 3;
        run_op(1'b0, 4998, 4, 32'h12345678, 1'b0);

        run_op(1'b1, 0, 0, 32'h0, 1'b0);
        run_op(1'b0, 100, 0, 32'h0, 1'b0);
        run_op(1'b1, 4996, 6, 32'h0000ABCD, 1'b1);
        run_op(1'b0, 20, 6, 32'h55AA0000, 1'b1);

        launch(1'b1, 0, 4, 32'hA5A50000);
        step();
        step();
        hold_valid = 1'b1;
        step();
        chk("rwait_busy", 64'(busy), 64'(1));
        reset_n = 1'b0;
        step();
        chk_reset("mid_reset");
        reset_n = 1'b1;
        hold_valid = 1'b0;
        avm_readdatavalid = 1'b1;
        avm_readdata = 32'h0BAD0BAD;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_done", 64'(done), 64'(0));
            chk("post_rst_busy", 64'(busy), 64'(0));
            chk("post_rst_req", 64'({avm_read, avm_write}), 64'(0));
            chk("post_rst_err", 64'(err_count), 64'(0));
        end
        run_op(1'b1, 0, 4, 32'hA5A50000, 1'b0);

        stall_pct = 25;
        lb = 0;
        ls = 32'hA5A50000;
        for (int k = 0; k < 30; k++) begin
            m = 1'($urandom_range(1));
            n = $urandom_range(40);
            b = ($urandom_range(3) == 0) ? DEPTH - 1 - $urandom_range(20) : $urandom_range(DEPTH - 1);
            s = $urandom;
            if (m && $urandom_range(2) != 0) begin
                b = lb;
                s = ls;
            end
            if (m && $urandom_range(2) == 0) begin
                a = (b + $urandom_range(n)) % DEPTH;
                v = $urandom;
                ram[a] = v;
                model[a] = v;
            end
            run_op(m, b, n, s, $urandom_range(4) == 0);
            if (!m) begin
                lb = b;
                ls = s;
            end
        end

        stall_pct = 10;
        s = $urandom;
        run_op(1'b0, 10, DEPTH + 3, s, 1'b0);
        run_op(1'b1, 10, DEPTH + 3, s, 1'b0);
        chk("overlap_err", 64'(err_count), 64'(3));
        chk("overlap_first", 64'(first_err_addr), 64'(10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
